tlb_ctrl: RTL
=============

TLB_CTRL -- requirements
Module: tlb_ctrl

Interface
REQ-001 SHALL provide parameter: ENTRIES, 32, number of TLB entries (power of two).
REQ-002 SHALL provide parameter: IDX_W, 5, index width (log2 ENTRIES).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: clk  in  1  rising-edge clock.
REQ-005 SHALL have port: rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port: op_valid  in  1  TLB instruction request from CP0/EX stage.
REQ-007 SHALL have port: op_code  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR.
REQ-008 SHALL have port: op_ready  out  1  request accepted when op_valid&&op_ready.
REQ-009 SHALL have port: op_done  out  1  one-cycle completion pulse.
REQ-010 SHALL have port: busy  out  1  operation in flight; pipeline stalls address translation.
REQ-011 SHALL have port: cp0_index  in  IDX_W  Index register entry field.
REQ-012 SHALL have port: cp0_wired  in  IDX_W  Wired register value.
REQ-013 SHALL have port: wired_wr  in  1  Wired register written this cycle.
REQ-014 SHALL have port: random  out  IDX_W  Random register value.
REQ-015 SHALL have port: tlb_probe  out  1  probe strobe; TLB compares current entryhi.
REQ-016 SHALL have port: tlb_hit / tlb_hit_idx  in  1 / IDX_W  probe result, valid cycle after tlb_probe.
REQ-017 SHALL have port: tlb_rd  out  1  read strobe; entry data valid cycle after.
REQ-018 SHALL have port: tlb_wen  out  1  write enable to TLB (entryhi/lo0/lo1/mask from CP0).
REQ-019 SHALL have port: tlb_idx  out  IDX_W  entry index for read/write.
REQ-020 SHALL have port: index_wen / index_wdata  out  1 / 32  Index register update {P, 26'b0, idx} (upper pad sized to 31-IDX_W).
REQ-021 SHALL have port: regs_wen  out  1  load EntryHi/EntryLo0/EntryLo1/PageMask from TLB read data.

Function
REQ-022 SHALL implement FSM states IDLE, PROBE, PWAIT, READ, RWAIT, WRITE, SETTLE.
REQ-023 SHALL assert op_ready only in IDLE; busy = (state != IDLE); op_valid outside IDLE ignored.
REQ-024 SHALL on accept (cycle T) latch op_code and the write index: cp0_index for TLBWI, current random for TLBWR.
REQ-025 SHALL TLBP: T+1 PROBE, tlb_probe=1; T+2 PWAIT, sample tlb_hit/tlb_hit_idx, index_wen=1, op_done=1; T+3 IDLE.
REQ-026 SHALL TLBP hit: index_wdata={0,pad,tlb_hit_idx}; miss: index_wdata=32'h80000000 (P=1, idx 0).
REQ-027 SHALL TLBR: T+1 READ, tlb_rd=1, tlb_idx=cp0_index latched; T+2 RWAIT, regs_wen=1, op_done=1; T+3 IDLE.
REQ-028 SHALL TLBWI/TLBWR: T+1 WRITE, tlb_wen=1 exactly one cycle, tlb_idx=latched index; T+2 SETTLE, op_done=1; T+3 IDLE.
REQ-029 SHALL hold tlb_idx stable at latched value throughout an operation; 0 in IDLE.
REQ-030 SHALL keep tlb_probe, tlb_rd, tlb_wen, index_wen, regs_wen, op_done single-cycle pulses, never two asserted together except index_wen/regs_wen with op_done.
REQ-031 SHALL decrement random every cycle: if random <= cp0_wired, next = ENTRIES-1; else random-1.
REQ-032 SHALL set random to ENTRIES-1 in the cycle after wired_wr=1, overriding decrement.
REQ-033 SHALL keep random counting during operations; TLBWR uses value sampled at accept, not later values.
REQ-034 SHALL, if cp0_wired >= ENTRIES-1, hold random at ENTRIES-1.
REQ-035 SHALL back-to-back: accept next op in the IDLE cycle at T+3 earliest; minimum 3-cycle issue interval.

Reset
REQ-036 SHALL on rst=1: state=IDLE, random=ENTRIES-1, latched regs 0, all strobes/op_done/index_wen/regs_wen 0, op_ready=1 from the cycle after reset deasserts.
REQ-037 SHALL abort any in-flight operation on rst mid-op: no op_done, no tlb_wen, no register updates in following cycles.
REQ-038 SHALL ignore op_valid in the cycle rst=1.

Verification
REQ-039 SHALL cover: reset, wired=0, 40 idle cycles -> random 31,30,...,0,31,... wraps, never below wired.
REQ-040 SHALL cover: TLBP with entryhi matching entry 1 (tlb_hit=1, idx=1) -> index_wdata=32'h00000001 at T+2; miss -> 32'h80000000.
REQ-041 SHALL cover: cp0_index=5, TLBWI -> tlb_wen single pulse T+1, tlb_idx=5, op_done T+2, busy T+1..T+2.
REQ-042 SHALL cover: wired=8, TLBWR when random=8 -> tlb_idx=8; next random=31; random never in 0..7.
REQ-043 SHALL cover: TLBR idx 0 -> tlb_rd T+1, regs_wen+op_done T+2; op_valid held high -> second accept at T+3 only.
REQ-044 SHALL cover: rst asserted at T+1 of TLBWI -> no tlb_wen/op_done after, random=31, op_ready=1 after release.

Source files
------------

// File: rtl/tlb_ctrl_if.sv
// TLB instruction controller bus: CP0/EX request side, TLB array side and CP0 register updates.
interface tlb_ctrl_if #(
    parameter int unsigned IDX_W = 5
);
    logic             op_valid;
    logic [1:0]       op_code;
    logic             op_ready;
    logic             op_done;
    logic             busy;
    logic [IDX_W-1:0] cp0_index;
    logic [IDX_W-1:0] cp0_wired;
    logic             wired_wr;
    logic [IDX_W-1:0] random;
    logic             tlb_probe;
    logic             tlb_hit;
    logic [IDX_W-1:0] tlb_hit_idx;
    logic             tlb_rd;
    logic             tlb_wen;
    logic [IDX_W-1:0] tlb_idx;
    logic             index_wen;
    logic [31:0]      index_wdata;
    logic             regs_wen;

    // Requester / environment side (CP0, EX stage, TLB array model)
    modport master (
        output op_valid, op_code, cp0_index, cp0_wired, wired_wr, tlb_hit, tlb_hit_idx,
        input  op_ready, op_done, busy, random, tlb_probe, tlb_rd, tlb_wen, tlb_idx,
               index_wen, index_wdata, regs_wen
    );

    // Controller side
    modport slave (
        input  op_valid, op_code, cp0_index, cp0_wired, wired_wr, tlb_hit, tlb_hit_idx,
        output op_ready, op_done, busy, random, tlb_probe, tlb_rd, tlb_wen, tlb_idx,
               index_wen, index_wdata, regs_wen
    );
endinterface

// File: rtl/tlb_ctrl.sv
// TLB instruction sequencer (TLBP/TLBR/TLBWI/TLBWR) with the CP0 Random register.
module tlb_ctrl #(
    parameter int unsigned ENTRIES = 32,
    parameter int unsigned IDX_W   = 5
) (
    input logic       clk,
    input logic       rst,
    tlb_ctrl_if.slave bus
);
    localparam int unsigned      PAD_W    = 31 - IDX_W;
    localparam logic [IDX_W-1:0] RAND_MAX = IDX_W'(ENTRIES - 1);
    localparam logic [1:0]       OP_TLBP  = 2'b00;
    localparam logic [1:0]       OP_TLBR  = 2'b01;
    localparam logic [1:0]       OP_TLBWR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_PROBE, S_PWAIT, S_READ, S_RWAIT, S_WRITE, S_SETTLE
    } state_t;

    state_t           state_q, state_d;
    logic             accept_c;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] random_q, random_d;
    logic             op_ready_q, op_ready_d;
    logic             busy_q, busy_d;
    logic             op_done_q, op_done_d;
    logic             tlb_probe_q, tlb_probe_d;
    logic             tlb_rd_q, tlb_rd_d;
    logic             tlb_wen_q, tlb_wen_d;
    logic             index_wen_q, index_wen_d;
    logic             regs_wen_q, regs_wen_d;
    logic [31:0]      index_wdata_c;

    // State register; reset also aborts any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: each operation is a fixed two-state sequence back to IDLE
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.op_valid) begin
                    accept_c = 1'b1;
                    case (bus.op_code)
                        OP_TLBP: state_d = S_PROBE;
                        OP_TLBR: state_d = S_READ;
                        default: state_d = S_WRITE;
                    endcase
                end
            end
            S_PROBE:  state_d = S_PWAIT;
            S_READ:   state_d = S_RWAIT;
            S_WRITE:  state_d = S_SETTLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they are registered yet aligned with the state
    always_comb begin
        op_ready_d    = 1'b0;
        busy_d        = 1'b0;
        op_done_d     = 1'b0;
        tlb_probe_d   = 1'b0;
        tlb_rd_d      = 1'b0;
        tlb_wen_d     = 1'b0;
        index_wen_d   = 1'b0;
        regs_wen_d    = 1'b0;
        index_wdata_c = '0;
        op_ready_d    = (state_d == S_IDLE);
        busy_d        = (state_d != S_IDLE);
        tlb_probe_d   = (state_d == S_PROBE);
        tlb_rd_d      = (state_d == S_READ);
        tlb_wen_d     = (state_d == S_WRITE);
        index_wen_d   = (state_d == S_PWAIT);
        regs_wen_d    = (state_d == S_RWAIT);
        op_done_d     = (state_d == S_PWAIT) || (state_d == S_RWAIT) || (state_d == S_SETTLE);
        // Probe result arrives in the PWAIT cycle itself, so the Index data is taken straight from it
        if (state_q == S_PWAIT) begin
            if (bus.tlb_hit) index_wdata_c = {1'b0, PAD_W'(0), bus.tlb_hit_idx};
            else             index_wdata_c = {1'b1, PAD_W'(0), IDX_W'(0)};
        end
    end

    // Latched entry index and the free-running Random register
    always_comb begin
        idx_d = idx_q;
        if (accept_c)               idx_d = (bus.op_code == OP_TLBWR) ? random_q : bus.cp0_index;
        else if (state_d == S_IDLE) idx_d = '0;

        if (bus.wired_wr)                  random_d = RAND_MAX;
        else if (random_q <= bus.cp0_wired) random_d = RAND_MAX;
        else                               random_d = random_q - IDX_W'(1);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            random_q    <= RAND_MAX;
            op_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            op_done_q   <= 1'b0;
            tlb_probe_q <= 1'b0;
            tlb_rd_q    <= 1'b0;
            tlb_wen_q   <= 1'b0;
            index_wen_q <= 1'b0;
            regs_wen_q  <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            random_q    <= random_d;
            op_ready_q  <= op_ready_d;
            busy_q      <= busy_d;
            op_done_q   <= op_done_d;
            tlb_probe_q <= tlb_probe_d;
            tlb_rd_q    <= tlb_rd_d;
            tlb_wen_q   <= tlb_wen_d;
            index_wen_q <= index_wen_d;
            regs_wen_q  <= regs_wen_d;
        end
    end

    assign bus.op_ready    = op_ready_q;
    assign bus.busy        = busy_q;
    assign bus.op_done     = op_done_q;
    assign bus.random      = random_q;
    assign bus.tlb_probe   = tlb_probe_q;
    assign bus.tlb_rd      = tlb_rd_q;
    assign bus.tlb_wen     = tlb_wen_q;
    assign bus.tlb_idx     = idx_q;
    assign bus.index_wen   = index_wen_q;
    assign bus.index_wdata = index_wdata_c;
    assign bus.regs_wen    = regs_wen_q;
endmodule
